// File: rtl/capture_scheduler.sv
// Capture scheduler for the shared Hawk/Owl camera receiver and S2MM DMA path.
// Latches capture requests, arbitrates round-robin, strobes the receiver, and
// supervises each attempt for lock, timeout and byte count, retrying failures.
module capture_scheduler #(
    parameter int SETTLE_CYC    = 4,
    parameter int BYTES_PER_PIX = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        hawk_req,
    input  logic        owl_req,
    input  logic [15:0] hawk_width,
    input  logic [15:0] hawk_height,
    input  logic [15:0] owl_width,
    input  logic [15:0] owl_height,
    input  logic [31:0] timeout_cycles,
    input  logic        serde_locked,
    input  logic        camera_in_progress,
    input  logic [31:0] dma_xfer_cnt,
    output logic        camera_sel,
    output logic        new_capture,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  status,
    output logic        error,
    output logic [1:0]  pending,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);
    localparam logic [31:0] BPP         = 32'(BYTES_PER_PIX);

    // Expected DMA byte count for a frame, truncated to the counter width.
    function automatic logic [31:0] frame_bytes(input logic [15:0] w, input logic [15:0] h);
        logic [31:0] px;
        px          = {16'd0, w} * {16'd0, h};
        frame_bytes = px * BPP;
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  pending_r, pend_clr_s;
    logic        sel_r, last_sel_r, pick_sel_s, dispatch_s;
    logic [7:0]  settle_r, settle_next_s;
    logic [7:0]  retry_r, retry_next_s;
    logic [31:0] expected_r, base_r, tmo_r, tmo_inc_s, delta_s;
    logic        tmo_hit_s, attempt_fail_s, strobe_cyc_s, waiting_s, enter_done_s;
    logic [1:0]  fail_code_s, done_status_s;
    logic        new_capture_r, busy_r, frame_done_r, error_r;
    logic [1:0]  status_r;
    logic [15:0] frames_ok_r, frames_err_r;

    // Next-state decode: arbitration, settle countdown, wait supervision and retry policy.
    always_comb begin
        state_next_s   = state_r;
        settle_next_s  = settle_r;
        retry_next_s   = retry_r;
        dispatch_s     = 1'b0;
        attempt_fail_s = 1'b0;
        fail_code_s    = 2'd0;
        done_status_s  = 2'd0;
        pend_clr_s     = 2'b00;
        tmo_inc_s      = tmo_r + 32'd1;
        tmo_hit_s      = (timeout_cycles != 32'd0) && (tmo_inc_s >= timeout_cycles);
        delta_s        = dma_xfer_cnt - base_r;
        strobe_cyc_s   = (state_r == ST_SETUP) && (settle_r == 8'd0);
        waiting_s      = (state_r == ST_WAIT_START) || (state_r == ST_WAIT_END);

        // Both pending: the camera not served last goes first.
        if (pending_r == 2'b11) begin
            pick_sel_s = ~last_sel_r;
        end else begin
            pick_sel_s = pending_r[1];
        end

        case (state_r)
            ST_IDLE: begin
                if (pending_r != 2'b00) begin
                    dispatch_s   = 1'b1;
                    retry_next_s = 8'd0;
                    pend_clr_s   = pick_sel_s ? 2'b10 : 2'b01;
                    if (!serde_locked) begin
                        state_next_s  = ST_DONE;
                        done_status_s = 2'd3;
                    end else begin
                        state_next_s  = ST_SETUP;
                        settle_next_s = SETTLE_LAST;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (settle_r == 8'd0) begin
                    state_next_s = ST_WAIT_START;
                end else begin
                    settle_next_s = settle_r - 8'd1;
                end
            end
            ST_WAIT_START: begin
                if (!serde_locked) begin
                    state_next_s  = ST_DONE;
                    done_status_s = 2'd3;
                end else if (tmo_hit_s) begin
                    attempt_fail_s = 1'b1;
                    fail_code_s    = 2'd1;
                end else if (camera_in_progress) begin
                    state_next_s = ST_WAIT_END;
                end else begin
                    state_next_s = ST_WAIT_START;
                end
            end
            ST_WAIT_END: begin
                if (!serde_locked) begin
                    state_next_s  = ST_DONE;
                    done_status_s = 2'd3;
                end else if (tmo_hit_s) begin
                    attempt_fail_s = 1'b1;
                    fail_code_s    = 2'd1;
                end else if (!camera_in_progress) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_WAIT_END;
                end
            end
            ST_CHECK: begin
                // Modular subtraction keeps the comparison correct across counter wrap.
                if (delta_s == expected_r) begin
                    state_next_s  = ST_DONE;
                    done_status_s = 2'd0;
                end else begin
                    attempt_fail_s = 1'b1;
                    fail_code_s    = 2'd2;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (attempt_fail_s) begin
            if (retry_r < RETRY_MAX) begin
                retry_next_s  = retry_r + 8'd1;
                state_next_s  = ST_SETUP;
                settle_next_s = SETTLE_LAST;
            end else begin
                state_next_s  = ST_DONE;
                done_status_s = fail_code_s;
            end
        end else begin
            retry_next_s = retry_next_s;
        end

        enter_done_s = (state_next_s == ST_DONE);
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch; a new request wins over the clear of its own dispatch.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending_r <= 2'b00;
        end else begin
            pending_r <= (pending_r & ~pend_clr_s) | {owl_req, hawk_req};
        end
    end

    // Per-request context: selection, expected size, byte-counter base and timeout count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_r      <= 1'b0;
            last_sel_r <= 1'b1;
            settle_r   <= 8'd0;
            retry_r    <= 8'd0;
            expected_r <= 32'd0;
            base_r     <= 32'd0;
            tmo_r      <= 32'd0;
        end else begin
            settle_r <= settle_next_s;
            retry_r  <= retry_next_s;
            if (dispatch_s) begin
                sel_r      <= pick_sel_s;
                last_sel_r <= pick_sel_s;
                expected_r <= pick_sel_s ? frame_bytes(owl_width, owl_height)
                                         : frame_bytes(hawk_width, hawk_height);
            end
            if (strobe_cyc_s) begin
                base_r <= dma_xfer_cnt;
                tmo_r  <= 32'd0;
            end else if (waiting_s) begin
                tmo_r <= tmo_inc_s;
            end
        end
    end

    // Registered outputs: strobe, busy, completion pulse, status and saturating counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            new_capture_r <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            status_r      <= 2'd0;
            error_r       <= 1'b0;
            frames_ok_r   <= 16'd0;
            frames_err_r  <= 16'd0;
        end else begin
            new_capture_r <= (state_next_s == ST_SETUP) && (settle_next_s == 8'd0);
            busy_r        <= (state_next_s != ST_IDLE);
            frame_done_r  <= enter_done_s;
            if (enter_done_s) begin
                status_r <= done_status_s;
                error_r  <= (done_status_s != 2'd0);
                if (done_status_s == 2'd0) begin
                    if (frames_ok_r != 16'hFFFF) begin
                        frames_ok_r <= frames_ok_r + 16'd1;
                    end
                end else begin
                    if (frames_err_r != 16'hFFFF) begin
                        frames_err_r <= frames_err_r + 16'd1;
                    end
                end
            end else if (dispatch_s) begin
                error_r <= 1'b0;
            end
        end
    end

    assign camera_sel  = sel_r;
    assign new_capture = new_capture_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign status      = status_r;
    assign error       = error_r;
    assign pending     = pending_r;
    assign frames_ok   = frames_ok_r;
    assign frames_err  = frames_err_r;

endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
- Sequences image captures on the shared camera receiver / S2MM DMA path between the Hawk and Owl cameras.
- Latches capture requests from the AXI4-Lite register bank and arbitrates round-robin between cameras.
- Drives camera select and the one-cycle capture strobe into the camera receiver, then supervises progress, timeout and byte count, retrying failed frames.
- Reports per-frame status and good/bad frame counters back to the register bank.

Parameters:
- SETTLE_CYC, 4: cycles camera_sel is held stable before new_capture fires (1..255).
- BYTES_PER_PIX, 2: DMA bytes per pixel used to compute expected frame size.
- MAX_RETRY, 2: retries after a timeout or short frame before reporting error.

Ports:
- sys_clk  in  1  system clock; all logic is in this domain.
- sys_rst  in  1  synchronous, active-high reset.
- hawk_req  in  1  single-cycle capture request for Hawk.
- owl_req  in  1  single-cycle capture request for Owl.
- hawk_width, hawk_height  in  16 each  Hawk frame geometry.
- owl_width, owl_height  in  16 each  Owl frame geometry.
- timeout_cycles  in  32  per-attempt timeout in sys_clk cycles; 0 disables timeout.
- serde_locked  in  1  camera-link deserializer lock.
- camera_in_progress  in  1  high while the receiver is streaming a frame.
- dma_xfer_cnt  in  32  free-running cumulative S2MM byte counter; wraps.
- camera_sel  out  1  0 = Hawk, 1 = Owl; registered.
- new_capture  out  1  one-cycle capture strobe to the receiver.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a request completes, pass or fail.
- status  out  2  result of last request: 0 ok, 1 timeout, 2 short/long frame, 3 not locked.
- error  out  1  high when status != 0; cleared at the next dispatch.
- pending  out  2  {owl, hawk} latched requests.
- frames_ok  out  16  count of good frames; saturates at 0xFFFF.
- frames_err  out  16  count of failed requests; saturates at 0xFFFF.

Behaviour:
- Reset values: camera_sel 0, new_capture 0, busy 0, frame_done 0, status 0, error 0, pending 0, counters 0, state IDLE, last_sel 1 (so Hawk wins the first tie).
- Request latching:
  - A req pulse sets its pending bit on the next cycle.
  - Duplicate requests while the bit is already set coalesce.
  - A request for the camera currently being captured re-queues it.
  - A pending bit clears on dispatch.
- IDLE:
  - If any pending bit is set, dispatch. If both are set, select !last_sel; otherwise select the set bit.
  - On dispatch, register camera_sel and last_sel, clear that pending bit, clear error, zero retry_cnt, and register expected = width*height*BYTES_PER_PIX truncated to 32 bits.
  - If serde_locked is low at dispatch, go directly to DONE with status 3 and no strobe.
- SETUP: hold for SETTLE_CYC cycles; new_capture is high for exactly one cycle on the last SETUP cycle.
  - Dispatch at cycle t gives new_capture at t+SETTLE_CYC.
  - On that same cycle, snapshot dma_xfer_cnt into base and clear tmo_cnt.
- WAIT_START: wait for camera_in_progress=1, then go to WAIT_END.
- WAIT_END: wait for camera_in_progress=0, then go to CHECK.
- Timeout:
  - tmo_cnt counts every cycle in WAIT_START and WAIT_END.
  - When timeout_cycles != 0 and tmo_cnt reaches timeout_cycles, the attempt fails with timeout.
- Lock loss: serde_locked low during WAIT_START or WAIT_END goes to DONE with status 3 immediately, with no retry.
- CHECK, which lasts one cycle:
  - delta = dma_xfer_cnt - base, modulo 2^32, so counter wrap is correct.
  - delta == expected: DONE with status 0.
  - Otherwise the attempt fails with status 2.
- Failed attempt (status 1 or 2):
  - If retry_cnt < MAX_RETRY, increment retry_cnt and return to SETUP with the same camera_sel and a fresh strobe.
  - Otherwise go to DONE with that status.
- DONE, which lasts one cycle:
  - Pulse frame_done.
  - Update status and error.
  - Increment frames_ok if status is 0, else increment frames_err.
  - Return to IDLE. A new dispatch can occur the following cycle.
- Simultaneous events:
  - hawk_req and owl_req in the same cycle set both bits.
  - A req arriving on the dispatch cycle of the same camera leaves its bit set (set wins over clear).
- Reset asserted mid-operation returns everything to reset values next edge; no strobe or frame_done is emitted.

Test Plan:
- SETTLE_CYC=4, lock=1, Hawk 640x512. hawk_req; stub raises in_progress 3 cycles after the strobe, adds 655360 bytes, drops. Required: camera_sel=0, new_capture exactly 4 cycles after dispatch, frame_done with status 0, frames_ok=1.
- hawk_req and owl_req in the same cycle after reset. Required: Hawk serviced first, then Owl (camera_sel 0 then 1); a second simultaneous pair after that is serviced Hawk then Owl again, giving round-robin alternation via last_sel.
- timeout_cycles=100, stub never raises in_progress, MAX_RETRY=2. Required: 3 strobes, each 100+SETTLE_CYC cycles apart; then frame_done with status 1, error=1, frames_err=1.
- base=0xFFFFFF00, Owl 16x16, 2 B/px, counter wraps to 0x00000100. Required: status 0. A second run delivering 510 bytes on every attempt ends in status 2 after 3 attempts.
- serde_locked=0 at request. Required: no new_capture, frame_done within 2 cycles, status 3. Lock dropped mid WAIT_END: immediate status 3, with no retry.
- sys_rst pulsed during WAIT_END with both pending bits set. Required: all outputs return to reset values, pending=0, and no frame_done is emitted.
